// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the SEQ decode stage: icodes, register indices, word width.
// Pure definitions plus source-select helpers; no timing or flow-control behaviour.
package y86_pkg;

  localparam int WORD_W   = 64;
  localparam int REG_W    = 4;
  localparam int NUM_REGS = 15;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [3:0]        icode_t;

  localparam icode_t IHALT   = 4'h0;
  localparam icode_t INOP    = 4'h1;
  localparam icode_t IRRMOVQ = 4'h2;
  localparam icode_t IIRMOVQ = 4'h3;
  localparam icode_t IRMMOVQ = 4'h4;
  localparam icode_t IMRMOVQ = 4'h5;
  localparam icode_t IOPQ    = 4'h6;
  localparam icode_t IJXX    = 4'h7;
  localparam icode_t ICALL   = 4'h8;
  localparam icode_t IRET    = 4'h9;
  localparam icode_t IPUSHQ  = 4'hA;
  localparam icode_t IPOPQ   = 4'hB;

  localparam reg_idx_t RRAX  = 4'h0;
  localparam reg_idx_t RRCX  = 4'h1;
  localparam reg_idx_t RRDX  = 4'h2;
  localparam reg_idx_t RRBX  = 4'h3;
  localparam reg_idx_t RRSP  = 4'h4;
  localparam reg_idx_t RRBP  = 4'h5;
  localparam reg_idx_t RRSI  = 4'h6;
  localparam reg_idx_t RRDI  = 4'h7;
  localparam reg_idx_t RR8   = 4'h8;
  localparam reg_idx_t RR9   = 4'h9;
  localparam reg_idx_t RR10  = 4'hA;
  localparam reg_idx_t RR11  = 4'hB;
  localparam reg_idx_t RR12  = 4'hC;
  localparam reg_idx_t RR13  = 4'hD;
  localparam reg_idx_t RR14  = 4'hE;
  localparam reg_idx_t RNONE = 4'hF;

  function automatic reg_idx_t src_a_sel(input icode_t icode, input reg_idx_t ra);
    reg_idx_t src;
    src = RNONE;
    case (icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src = ra;
      IRET, IPOPQ:                    src = RRSP;
      default:                        src = RNONE;
    endcase
    return src;
  endfunction

  function automatic reg_idx_t src_b_sel(input icode_t icode, input reg_idx_t rb);
    reg_idx_t src;
    src = RNONE;
    case (icode)
      IRMMOVQ, IMRMOVQ, IOPQ:     src = rb;
      ICALL, IRET, IPUSHQ, IPOPQ: src = RRSP;
      default:                    src = RNONE;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/decode_module_if.sv
// Fetch-to-decode bus: instruction fields in, registered operands out.
// No handshake; the consumer samples every cycle.
interface decode_module_if;
  import y86_pkg::*;

  icode_t   icode;
  reg_idx_t rA;
  reg_idx_t rB;
  word_t    valA;
  word_t    valB;

  modport master (output icode, rA, rB, input valA, valB);
  modport slave  (input icode, rA, rB, output valA, valB);

endinterface

// File: rtl/reg_read_mux.sv
// 16-way register read port: indices 0..14 select a word, 0xF (none) reads as zero.
// Purely combinational; no backpressure.
module reg_read_mux
  import y86_pkg::*;
(
  input  reg_idx_t                 idx,
  input  logic [NUM_REGS-1:0][WORD_W-1:0] regs,
  output word_t                    rd
);

  always_comb begin
    rd = '0;
    if (idx != RNONE) begin
      rd = regs[idx];
    end
  end

endmodule

// File: rtl/decode_module.sv
// Y86-64 SEQ decode: selects srcA/srcB from icode and reads them out of the register file.
// Latency 1 cycle (registered valA/valB); accepts a new instruction every cycle, no stall.
module decode_module
  import y86_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  decode_module_if.slave   dif,
  input  word_t            rax,
  input  word_t            rcx,
  input  word_t            rdx,
  input  word_t            rbx,
  input  word_t            rsp,
  input  word_t            rbp,
  input  word_t            rsi,
  input  word_t            rdi,
  input  word_t            r8,
  input  word_t            r9,
  input  word_t            r10,
  input  word_t            r11,
  input  word_t            r12,
  input  word_t            r13,
  input  word_t            r14
);

  logic [NUM_REGS-1:0][WORD_W-1:0] reg_file;
  reg_idx_t src_a;
  reg_idx_t src_b;
  word_t    rd_a;
  word_t    rd_b;
  word_t    valA_d;
  word_t    valB_d;
  word_t    valA_q;
  word_t    valB_q;

  // Packed so that index i of reg_file is architectural register i.
  assign reg_file = {r14, r13, r12, r11, r10, r9, r8,
                     rdi, rsi, rbp, rsp, rbx, rdx, rcx, rax};

  always_comb begin
    src_a = src_a_sel(dif.icode, dif.rA);
    src_b = src_b_sel(dif.icode, dif.rB);
  end

  reg_read_mux u_read_a (
    .idx  (src_a),
    .regs (reg_file),
    .rd   (rd_a)
  );

  reg_read_mux u_read_b (
    .idx  (src_b),
    .regs (reg_file),
    .rd   (rd_b)
  );

  always_comb begin
    valA_d = rd_a;
    valB_d = rd_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valA_q <= '0;
      valB_q <= '0;
    end else begin
      valA_q <= valA_d;
      valB_q <= valB_d;
    end
  end

  assign dif.valA = valA_q;
  assign dif.valB = valB_q;

endmodule

// File: tb/tb_decode_module.sv
// Directed, table-driven check of decode_module against hand-computed operands.
module tb_decode_module;

  logic clk = 1'b0;
  logic reset;
  logic [63:0] rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi;
  logic [63:0] r8, r9, r10, r11, r12, r13, r14;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_module_if dif ();

  decode_module dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif),
    .rax (rax), .rcx (rcx), .rdx (rdx), .rbx (rbx),
    .rsp (rsp), .rbp (rbp), .rsi (rsi), .rdi (rdi),
    .r8  (r8),  .r9  (r9),  .r10 (r10), .r11 (r11),
    .r12 (r12), .r13 (r13), .r14 (r14)
  );

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b);
    dif.icode = ic;
    dif.rA    = a;
    dif.rB    = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                              input logic [63:0] ea, input logic [63:0] eb);
    vec_t v;
    v.icode = ic; v.ra = a; v.rb = b; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  initial begin
    rax = 64'h1000; rcx = 64'h1001; rdx = 64'h1002; rbx = 64'h1003;
    rsp = 64'h1004; rbp = 64'h1005; rsi = 64'h1006; rdi = 64'h1007;
    r8  = 64'h1008; r9  = 64'h1009; r10 = 64'h100A; r11 = 64'h100B;
    r12 = 64'h100C; r13 = 64'h100D; r14 = 64'h100E;

    vecs[0]  = mk(4'h2, 4'd1,  4'd8,  64'h1001, 64'h0);
    vecs[1]  = mk(4'h3, 4'd2,  4'd2,  64'h0,    64'h0);
    vecs[2]  = mk(4'h4, 4'd3,  4'd3,  64'h1003, 64'h1003);
    vecs[3]  = mk(4'h5, 4'd4,  4'd4,  64'h0,    64'h1004);
    vecs[4]  = mk(4'h6, 4'd14, 4'd0,  64'h100E, 64'h1000);
    vecs[5]  = mk(4'h8, 4'd3,  4'd5,  64'h0,    64'h1004);
    vecs[6]  = mk(4'h9, 4'd9,  4'd9,  64'h1004, 64'h1004);
    vecs[7]  = mk(4'hA, 4'd10, 4'hF,  64'h100A, 64'h1004);
    vecs[8]  = mk(4'hB, 4'd11, 4'd1,  64'h1004, 64'h1004);
    vecs[9]  = mk(4'h2, 4'hF,  4'd3,  64'h0,    64'h0);
    vecs[10] = mk(4'h0, 4'd1,  4'd2,  64'h0,    64'h0);
    vecs[11] = mk(4'h1, 4'd3,  4'd4,  64'h0,    64'h0);
    vecs[12] = mk(4'h7, 4'd5,  4'd6,  64'h0,    64'h0);
    vecs[13] = mk(4'hC, 4'd1,  4'd2,  64'h0,    64'h0);
    vecs[14] = mk(4'hD, 4'd7,  4'd8,  64'h0,    64'h0);
    vecs[15] = mk(4'hE, 4'd4,  4'd4,  64'h0,    64'h0);
    vecs[16] = mk(4'hF, 4'd0,  4'd14, 64'h0,    64'h0);
    vecs[17] = mk(4'h6, 4'hF,  4'hF,  64'h0,    64'h0);
    vecs[18] = mk(4'h4, 4'd7,  4'hF,  64'h1007, 64'h0);
    vecs[19] = mk(4'h6, 4'd5,  4'd5,  64'h1005, 64'h1005);

    // Reset held two edges with a live decode on the inputs.
    reset = 1'b1;
    drive(4'h6, 4'd1, 4'd2);
    tick();
    check("reset1.valA", dif.valA, 64'h0);
    check("reset1.valB", dif.valB, 64'h0);
    tick();
    check("reset2.valA", dif.valA, 64'h0);
    check("reset2.valB", dif.valB, 64'h0);
    reset = 1'b0;
    tick();
    check("post_reset.valA", dif.valA, 64'h1001);
    check("post_reset.valB", dif.valB, 64'h1002);

    // Back-to-back: a new vector on every edge, each checked one cycle later.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].icode, vecs[i].ra, vecs[i].rb);
      tick();
      check($sformatf("vec%0d.valA", i), dif.valA, vecs[i].exp_a);
      check($sformatf("vec%0d.valB", i), dif.valB, vecs[i].exp_b);
    end

    // rcx changes between edges; outputs follow only after the next edge.
    drive(4'h6, 4'd1, 4'd1);
    tick();
    check("rcx_old.valA", dif.valA, 64'h1001);
    #2 rcx = 64'hBEEF;
    #1;
    check("rcx_mid.valA", dif.valA, 64'h1001);
    check("rcx_mid.valB", dif.valB, 64'h1001);
    tick();
    check("rcx_new.valA", dif.valA, 64'hBEEF);
    check("rcx_new.valB", dif.valB, 64'hBEEF);
    rcx = 64'h1001;

    // Reset asserted mid-run overrides a non-zero decode.
    reset = 1'b1;
    drive(4'hB, 4'd0, 4'd0);
    tick();
    check("reset_mid.valA", dif.valA, 64'h0);
    check("reset_mid.valB", dif.valB, 64'h0);
    reset = 1'b0;
    tick();
    check("reset_rel.valA", dif.valA, 64'h1004);
    check("reset_rel.valB", dif.valB, 64'h1004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
